des_key_schedule: RTL

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

---
 rtl/des_key_schedule.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/des_key_schedule.sv
// DES key schedule: expands a 64-bit key into sixteen 48-bit round subkeys,
// emitted one per valid/ready handshake in encrypt (K1..K16) or decrypt
// (K16..K1) order. C/D rotate forward for encrypt and backward for decrypt,
// so no subkey storage is needed in either direction.
module des_key_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key_in,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic {IDLE = 1'b0, GEN = 1'b1} state_t;

    // PC-1: 56 key bit positions (1 = MSB of key_in); parity bits never appear
    localparam logic [6:0] PC1_TAB [0:55] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
        7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
        7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
        7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
        7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
    };

    // PC-2: 48 positions into the 56-bit {C,D} (1 = MSB of C)
    localparam logic [5:0] PC2_TAB [0:47] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = 56'd0;
        for (int i = 0; i < 56; i++) begin
            r[55 - i] = k[64 - int'(PC1_TAB[i])];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = 48'd0;
        for (int i = 0; i < 48; i++) begin
            r[47 - i] = cd[56 - int'(PC2_TAB[i])];
        end
        return r;
    endfunction

    // Rotation applied to produce emission idx. Decrypt walks the encrypt
    // shifts backwards; its first emission is the unrotated PC-1 state,
    // because the 16 encrypt shifts sum to 28 (a full turn).
    function automatic logic [1:0] shift_amt(input logic [3:0] idx, input logic dec);
        logic [1:0] a;
        if (dec && (idx == 4'd0)) begin
            a = 2'd0;
        end else if (dec) begin
            a = ((idx == 4'd1) || (idx == 4'd8) || (idx == 4'd15)) ? 2'd1 : 2'd2;
        end else begin
            a = ((idx == 4'd0) || (idx == 4'd1) || (idx == 4'd8) || (idx == 4'd15)) ? 2'd1 : 2'd2;
        end
        return a;
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] amt,
                                          input logic right);
        logic [27:0] r;
        case (amt)
            2'd1:    r = right ? {x[0], x[27:1]}   : {x[26:0], x[27]};
            2'd2:    r = right ? {x[1:0], x[27:2]} : {x[25:0], x[27:26]};
            default: r = x;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [47:0] subkey_q, subkey_d;
    logic        valid_q, valid_d;
    logic [3:0]  idx_q, idx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dec_q, dec_d;

    logic [55:0] cd0_s;
    logic [3:0]  next_idx_s;
    logic [1:0]  amt_s;

    // Next-state logic: load on accepted start, advance on handshake, finish after index 15
    always_comb begin
        state_d    = state_q;
        c_d        = c_q;
        d_d        = d_q;
        subkey_d   = subkey_q;
        valid_d    = valid_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        dec_d      = dec_q;
        cd0_s      = 56'd0;
        next_idx_s = 4'd0;
        amt_s      = 2'd0;
        if (state_q == IDLE) begin
            // start coinciding with the done pulse is not taken
            if (start && !done_q) begin
                cd0_s    = pc1(key_in);
                amt_s    = shift_amt(4'd0, decrypt);
                c_d      = rot28(cd0_s[55:28], amt_s, decrypt);
                d_d      = rot28(cd0_s[27:0], amt_s, decrypt);
                subkey_d = pc2({c_d, d_d});
                dec_d    = decrypt;
                idx_d    = 4'd0;
                valid_d  = 1'b1;
                state_d  = GEN;
            end else begin
                valid_d  = 1'b0;
            end
        end else begin
            if (valid_q && subkey_ready) begin
                if (idx_q == 4'd15) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    idx_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    next_idx_s = idx_q + 4'd1;
                    amt_s      = shift_amt(next_idx_s, dec_q);
                    c_d        = rot28(c_q, amt_s, dec_q);
                    d_d        = rot28(d_q, amt_s, dec_q);
                    subkey_d   = pc2({c_d, d_d});
                    idx_d      = next_idx_s;
                end
            end else begin
                state_d = state_q;
            end
        end
        busy_d = (state_d == GEN);
    end

    // State and output registers; reset aborts any schedule without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            c_q      <= 28'd0;
            d_q      <= 28'd0;
            subkey_q <= 48'd0;
            valid_q  <= 1'b0;
            idx_q    <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dec_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            d_q      <= d_d;
            subkey_q <= subkey_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dec_q    <= dec_d;
        end
    end

    assign subkey       = subkey_q;
    assign subkey_valid = valid_q;
    assign round_idx    = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
